// File: rtl/idct4_stream_sched.sv
// Flow-control sequencer for the 4-tap IDCT column datapath: skews each accepted
// vector across the lanes and buffers results in a credit-protected tagged FIFO.
module idct4_stream_sched #(
    parameter int W          = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int BLOCK_ROWS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x1,
    input  logic [W-1:0] in_x2,
    input  logic [W-1:0] in_x3,
    input  logic [W-1:0] in_x4,
    output logic [W-1:0] dp_in_1,
    output logic [W-1:0] dp_in_2,
    output logic [W-1:0] dp_in_3,
    output logic [W-1:0] dp_in_4,
    input  logic [W-1:0] dp_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = CW + 1;
    localparam int RW = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

    logic [4:0]    r_vp;
    logic [W-1:0]  r_sk2, r_sk3a, r_sk3b, r_sk4a, r_sk4b, r_sk4c;
    logic [W-1:0]  r_dp1, r_dp2, r_dp3, r_dp4;
    logic [W:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_row;
    logic          r_err;

    logic [2:0]    w_inflight;
    logic [UW-1:0] w_used;
    logic          w_acc, w_wr, w_pop, w_full, w_do_wr, w_have, w_row_last;
    logic [W:0]    w_head;

    // Credit counts every vector already committed to the pipe, so the FIFO can never overflow.
    assign w_inflight = 3'(r_vp[0]) + 3'(r_vp[1]) + 3'(r_vp[2]) + 3'(r_vp[3]) + 3'(r_vp[4]);
    assign w_used     = UW'(r_count) + UW'(w_inflight);
    assign in_ready   = !flush && reset_n && (w_used < UW'(FIFO_DEPTH));

    assign w_acc      = in_valid && in_ready;
    assign w_wr       = r_vp[4];
    assign w_have     = (r_count != '0);
    assign w_pop      = w_have && out_ready;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_do_wr    = w_wr && (!w_full || w_pop);
    assign w_row_last = (r_row == RW'(BLOCK_ROWS - 1));
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vp   <= '0;
            r_sk2  <= '0;
            r_sk3a <= '0;
            r_sk3b <= '0;
            r_sk4a <= '0;
            r_sk4b <= '0;
            r_sk4c <= '0;
            r_dp1  <= '0;
            r_dp2  <= '0;
            r_dp3  <= '0;
            r_dp4  <= '0;
        end else if (flush) begin
            r_vp   <= '0;
            r_sk2  <= '0;
            r_sk3a <= '0;
            r_sk3b <= '0;
            r_sk4a <= '0;
            r_sk4b <= '0;
            r_sk4c <= '0;
            r_dp1  <= '0;
            r_dp2  <= '0;
            r_dp3  <= '0;
            r_dp4  <= '0;
        end else begin
            r_vp   <= {r_vp[3:0], w_acc};
            r_sk2  <= in_x2;
            r_sk3a <= in_x3;
            r_sk3b <= r_sk3a;
            r_sk4a <= in_x4;
            r_sk4b <= r_sk4a;
            r_sk4c <= r_sk4b;
            // Each lane is gated by the valid bit of the vector owning its slot.
            r_dp1  <= w_acc   ? in_x1  : '0;
            r_dp2  <= r_vp[0] ? r_sk2  : '0;
            r_dp3  <= r_vp[1] ? r_sk3b : '0;
            r_dp4  <= r_vp[2] ? r_sk4c : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !flush) begin
            r_mem[r_wr_ptr] <= {w_row_last, dp_out};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_row    <= '0;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_row    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_row    <= w_row_last ? '0 : r_row + 1'b1;
            end
            if (w_wr && !w_do_wr) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dp_in_1   = r_dp1;
    assign dp_in_2   = r_dp2;
    assign dp_in_3   = r_dp3;
    assign dp_in_4   = r_dp4;
    assign out_valid = w_have;
    assign out_data  = w_have ? w_head[W-1:0] : '0;
    assign out_last  = w_have ? w_head[W] : 1'b0;
    assign busy      = (|r_vp) || w_have;
    assign err_ovf   = r_err;

endmodule

// File: tb/tb_idct4_stream_sched.sv
// Bench for idct4_stream_sched: a transposed-chain datapath stub closes the loop, and a
// queue-based model of accepted vectors predicts every output.
module tb_idct4_stream_sched;

    localparam int W  = 25;
    localparam int D  = 8;
    localparam int BR = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_x1 = '0, in_x2 = '0, in_x3 = '0, in_x4 = '0;
    logic [W-1:0] dp_in_1, dp_in_2, dp_in_3, dp_in_4, out_data;
    logic [W-1:0] dp_out;
    logic         in_ready, out_valid, out_last, busy, err_ovf;

    idct4_stream_sched #(.W(W), .FIFO_DEPTH(D), .BLOCK_ROWS(BR)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
        .dp_in_1(dp_in_1), .dp_in_2(dp_in_2), .dp_in_3(dp_in_3), .dp_in_4(dp_in_4),
        .dp_out(dp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Datapath stub: transposed adder chain, result registered at the fourth lane edge.
    logic signed [47:0] p1, p2, p3, w_fin;
    assign w_fin = p3 + 48'(36 * $signed(dp_in_4)) + 48'sd64;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1 <= '0; p2 <= '0; p3 <= '0; dp_out <= '0;
        end else begin
            p1     <= 48'(64 * $signed(dp_in_1));
            p2     <= p1 + 48'(83 * $signed(dp_in_2));
            p3     <= p2 + 48'(64 * $signed(dp_in_3));
            dp_out <= w_fin[W+6:7];
        end
    end

    typedef struct {
        logic [W-1:0] d;
        logic         last;
        int           rdy;
    } exp_t;

    exp_t         q[$];
    int           outstanding = 0;
    int           row_idx = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_err = 0;
    int           n_dut_acc = 0;
    logic         hv[4];
    logic [W-1:0] hx[4][4];

    function automatic logic [W-1:0] ref_idct(input logic [W-1:0] a, b, c, d);
        longint s;
        s = 64 * longint'($signed(a)) + 83 * longint'($signed(b))
          + 64 * longint'($signed(c)) + 36 * longint'($signed(d)) + 64;
        s = s >>> 7;
        return s[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        outstanding = 0;
        row_idx = 0;
        for (int i = 0; i < 4; i++) hv[i] = 1'b0;
    endtask

    task automatic check_outputs();
        logic exp_ov;
        exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("in_ready", in_ready, W'(!flush && outstanding < D));
        chk("out_valid", out_valid, W'(exp_ov));
        if (exp_ov) begin
            chk("out_data", out_data, q[0].d);
            chk("out_last", out_last, W'(q[0].last));
        end
        chk("busy", busy, W'(outstanding != 0));
        chk("err_ovf", err_ovf, '0);
        chk("dp_in_1", dp_in_1, hv[0] ? hx[0][0] : '0);
        chk("dp_in_2", dp_in_2, hv[1] ? hx[1][1] : '0);
        chk("dp_in_3", dp_in_3, hv[2] ? hx[2][2] : '0);
        chk("dp_in_4", dp_in_4, hv[3] ? hx[3][3] : '0);
    endtask

    // One clock: drive at negedge, check, advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, b, c, d,
                         input logic rdy, input logic fl);
        logic acc, pop;
        in_valid = v; in_x1 = a; in_x2 = b; in_x3 = c; in_x4 = d;
        out_ready = rdy; flush = fl;
        #1;
        check_outputs();
        if (in_valid && in_ready) n_dut_acc++;
        acc = v && !fl && (outstanding < D);
        pop = rdy && (q.size() > 0) && (q[0].rdy <= cyc);
        @(posedge clk);
        cyc++;
        if (fl) begin
            model_clear();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                outstanding--;
            end
            for (int i = 3; i > 0; i--) begin
                hv[i] = hv[i-1];
                hx[i] = hx[i-1];
            end
            hv[0] = acc;
            hx[0][0] = a; hx[0][1] = b; hx[0][2] = c; hx[0][3] = d;
            if (acc) begin
                q.push_back('{ref_idct(a, b, c, d), (row_idx == BR - 1), cyc + 5});
                row_idx = (row_idx + 1) % BR;
                outstanding++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, '0);
        chk({tag, "_out_valid"}, out_valid, '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_out_last"}, out_last, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_err_ovf"}, err_ovf, '0);
        chk({tag, "_dp1"}, dp_in_1, '0);
        chk({tag, "_dp2"}, dp_in_2, '0);
        chk({tag, "_dp3"}, dp_in_3, '0);
        chk({tag, "_dp4"}, dp_in_4, '0);
    endtask

    initial begin
        int acc0;
        logic [W-1:0] m128;
        model_clear();
        m128 = -25'sd128;

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single (1,1,1,1) vector: result 2 exactly five cycles after accept
        cycle(1'b1, 25'd1, 25'd1, 25'd1, 25'd1, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("t1_valid", out_valid, 25'd1);
        chk("t1_data", out_data, 25'd2);
        chk("t1_last", out_last, '0);
        idle(3, 1'b1);

        // +128 then -128 back-to-back
        cycle(1'b1, 25'd128, '0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, m128, '0, '0, '0, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("t2_first", out_data, 25'd64);
        idle(1, 1'b1);
        chk("t2_second", out_data, -25'sd64);
        idle(3, 1'b1);

        // Eight back-to-back random vectors, consumer always ready
        for (int i = 0; i < 8; i++)
            cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(10, 1'b1);

        // Stalled consumer: exactly eight accepts then backpressure
        acc0 = n_dut_acc;
        for (int i = 0; i < 14; i++)
            cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0);
        chk("stall_accepts", W'(n_dut_acc - acc0), 25'd8);
        #1;
        chk("stall_in_ready", in_ready, '0);
        idle(16, 1'b1);
        chk("stall_err_ovf", err_ovf, '0);

        // Flush with three vectors in flight
        for (int i = 0; i < 3; i++)
            cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        idle(8, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(8, 1'b1);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom),
                  W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        idle(20, 1'b1);

        // Async reset with five in flight and three queued
        for (int i = 0; i < 8; i++)
            cycle(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0);
        chk("pre_reset_busy", busy, 25'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(12, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
